// File: rtl/enigma_rotor_gen2_if.sv
`default_nettype none
// ============================================================================
// Module   : enigma_rotor_gen2_if
// Purpose  : Bundle of configuration, stepping, substitution and status
//            signals between an Enigma rotor and its controller/datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface enigma_rotor_gen2_if #(
  parameter int W = 5
);
  logic         load_config;
  logic [W-1:0] init_pos;
  logic [W-1:0] init_ring;
  logic         step_enable;
  logic         in_valid_fwd;
  logic [W-1:0] char_in_fwd;
  logic         out_valid_fwd;
  logic [W-1:0] char_out_fwd;
  logic         in_valid_bwd;
  logic [W-1:0] char_in_bwd;
  logic         out_valid_bwd;
  logic [W-1:0] char_out_bwd;
  logic [W-1:0] current_pos;
  logic [W-1:0] ring_setting;
  logic         at_notch;
  logic         notch_pulse;
  logic         config_err;

  modport master (
    output load_config, init_pos, init_ring, step_enable,
           in_valid_fwd, char_in_fwd, in_valid_bwd, char_in_bwd,
    input  out_valid_fwd, char_out_fwd, out_valid_bwd, char_out_bwd,
           current_pos, ring_setting, at_notch, notch_pulse, config_err
  );

  modport slave (
    input  load_config, init_pos, init_ring, step_enable,
           in_valid_fwd, char_in_fwd, in_valid_bwd, char_in_bwd,
    output out_valid_fwd, char_out_fwd, out_valid_bwd, char_out_bwd,
           current_pos, ring_setting, at_notch, notch_pulse, config_err
  );
endinterface
`default_nettype wire

// File: rtl/enigma_rotor_gen2.sv
`default_nettype none
// ============================================================================
// Module   : enigma_rotor_gen2
// Purpose  : Parametrised Enigma rotor with runtime ring setting, up to two
//            notches, forward/backward substitution and stepping status.
//            Optional macro ROTOR_PIPE_EN registers the substitution outputs
//            (latency 1); without it the outputs are combinational.
// Revision : 1.0 - initial release
// ============================================================================
module enigma_rotor_gen2 #(
  parameter int           N             = 26,
  parameter int           W             = 5,
  parameter logic [W-1:0] MAP_FWD [N]   = '{5'd4,  5'd10, 5'd12, 5'd5,  5'd11, 5'd6,  5'd3,
                                            5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14, 5'd22,
                                            5'd24, 5'd7,  5'd23, 5'd20, 5'd18, 5'd15, 5'd0,
                                            5'd8,  5'd1,  5'd17, 5'd2,  5'd9},
  parameter int           NOTCH_A       = 16,
  parameter int           NOTCH_B       = 16
) (
  input  wire logic           clk,
  input  wire logic           reset,
  enigma_rotor_gen2_if.slave  rot
);

  localparam logic [W:0]   c_N       = (W+1)'(N);
  localparam logic [W-1:0] c_LAST    = W'(N - 1);
  localparam logic [W-1:0] c_NOTCH_A = W'(NOTCH_A);
  localparam logic [W-1:0] c_NOTCH_B = W'(NOTCH_B);

  // Parameter sanity: wiring must be a permutation, notches inside the alphabet.
  function automatic bit f_cfg_ok();
    bit       ok;
    bit [N-1:0] seen;
    ok   = (N >= 2) && (N <= (1 << W)) && (NOTCH_A < N) && (NOTCH_B < N);
    seen = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(MAP_FWD[i]) >= N)      ok = 1'b0;
      else if (seen[MAP_FWD[i]])      ok = 1'b0;
      else                            seen[MAP_FWD[i]] = 1'b1;
    end
    return ok;
  endfunction

  localparam bit c_CFG_OK = f_cfg_ok();

  if (!c_CFG_OK) begin : g_cfg_bad
    $error("enigma_rotor_gen2: invalid N/W/MAP_FWD/NOTCH parameters");
  end

  // Modular add/sub on W+1-bit operands already reduced below N.
  function automatic logic [W:0] f_add_mod(input logic [W:0] a, input logic [W:0] b);
    logic [W:0] s;
    s = a + b;
    if (s >= c_N) s = s - c_N;
    return s;
  endfunction

  function automatic logic [W:0] f_sub_mod(input logic [W:0] a, input logic [W:0] b);
    return (a >= b) ? (a - b) : (a + c_N - b);
  endfunction

  logic [W-1:0] pos_q, pos_d;
  logic [W-1:0] ring_q, ring_d;
  logic         np_q, np_d;
  logic         err_q, err_d;
  logic         w_at_notch;
  logic         w_load_bad;
  logic [W-1:0] map_bwd [N];
  logic [W-1:0] w_chr_fwd, w_chr_bwd;

  assign w_at_notch = (pos_q == c_NOTCH_A) || (pos_q == c_NOTCH_B);
  assign w_load_bad = ({1'b0, rot.init_pos} >= c_N) || ({1'b0, rot.init_ring} >= c_N);

  // Inverse wiring derived from the forward table (constant after elaboration).
  always_comb begin
    map_bwd = '{default: '0};
    for (int i = 0; i < N; i++) map_bwd[MAP_FWD[i]] = W'(i);
  end

  // Substitution through the rotor in both directions using the current position.
  always_comb begin
    logic [W:0]   pos_x, ring_x, idx_f, idx_b, res_f, res_b;
    logic [W-1:0] m_f, m_b;
    pos_x  = {1'b0, pos_q};
    ring_x = {1'b0, ring_q};
    idx_f  = f_sub_mod(f_add_mod({1'b0, rot.char_in_fwd}, pos_x), ring_x);
    idx_b  = f_sub_mod(f_add_mod({1'b0, rot.char_in_bwd}, pos_x), ring_x);
    m_f    = ({1'b0, rot.char_in_fwd} < c_N) ? MAP_FWD[idx_f[W-1:0]] : '0;
    m_b    = ({1'b0, rot.char_in_bwd} < c_N) ? map_bwd[idx_b[W-1:0]] : '0;
    res_f  = f_sub_mod(f_add_mod({1'b0, m_f}, ring_x), pos_x);
    res_b  = f_sub_mod(f_add_mod({1'b0, m_b}, ring_x), pos_x);
    w_chr_fwd = '0;
    w_chr_bwd = '0;
    if (rot.in_valid_fwd)
      w_chr_fwd = ({1'b0, rot.char_in_fwd} >= c_N) ? rot.char_in_fwd : res_f[W-1:0];
    if (rot.in_valid_bwd)
      w_chr_bwd = ({1'b0, rot.char_in_bwd} >= c_N) ? rot.char_in_bwd : res_b[W-1:0];
  end

  // Next position/ring/status: load beats step, a bad load holds state and flags an error.
  always_comb begin
    pos_d  = pos_q;
    ring_d = ring_q;
    np_d   = 1'b0;
    err_d  = 1'b0;
    if (rot.load_config) begin
      if (w_load_bad) begin
        err_d = 1'b1;
      end else begin
        pos_d  = rot.init_pos;
        ring_d = rot.init_ring;
      end
    end else if (rot.step_enable) begin
      np_d  = w_at_notch;
      pos_d = (pos_q == c_LAST) ? '0 : pos_q + 1'b1;
    end
  end

  // Position, ring and status pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q  <= '0;
      ring_q <= '0;
      np_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      ring_q <= ring_d;
      np_q   <= np_d;
      err_q  <= err_d;
    end
  end

  assign rot.current_pos  = pos_q;
  assign rot.ring_setting = ring_q;
  assign rot.at_notch     = w_at_notch;
  assign rot.notch_pulse  = np_q;
  assign rot.config_err   = err_q;

`ifdef ROTOR_PIPE_EN
  logic         vf_q, vb_q;
  logic [W-1:0] cf_q, cb_q;

  // Output stage: one cycle of latency on both substitution paths.
  always_ff @(posedge clk) begin
    if (reset) begin
      vf_q <= 1'b0;
      vb_q <= 1'b0;
      cf_q <= '0;
      cb_q <= '0;
    end else begin
      vf_q <= rot.in_valid_fwd;
      vb_q <= rot.in_valid_bwd;
      cf_q <= w_chr_fwd;
      cb_q <= w_chr_bwd;
    end
  end

  assign rot.out_valid_fwd = vf_q;
  assign rot.out_valid_bwd = vb_q;
  assign rot.char_out_fwd  = cf_q;
  assign rot.char_out_bwd  = cb_q;
`else
  assign rot.out_valid_fwd = rot.in_valid_fwd;
  assign rot.out_valid_bwd = rot.in_valid_bwd;
  assign rot.char_out_fwd  = w_chr_fwd;
  assign rot.char_out_bwd  = w_chr_bwd;
`endif

endmodule
`default_nettype wire

// File: tb/tb_enigma_rotor_gen2.sv
`default_nettype none
// ============================================================================
// Module   : tb_enigma_rotor_gen2
// Purpose  : Scoreboard bench for enigma_rotor_gen2 (two instances: single
//            notch at 16, and dual notch at 25/12). Works with or without
//            ROTOR_PIPE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enigma_rotor_gen2;

  localparam int N = 26;
  localparam int W = 5;
`ifdef ROTOR_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  enigma_rotor_gen2_if #(.W(W)) bus0();
  enigma_rotor_gen2_if #(.W(W)) bus1();

  enigma_rotor_gen2 #(.N(N), .W(W)) u_dut0 (
    .clk   (clk),
    .reset (rst),
    .rot   (bus0.slave)
  );

  enigma_rotor_gen2 #(.N(N), .W(W), .NOTCH_A(25), .NOTCH_B(12)) u_dut1 (
    .clk   (clk),
    .reset (rst),
    .rot   (bus1.slave)
  );

  // Reference wiring: rotor I as letters EKMFLGDQVZNTOWYHXUSPAIBRCJ.
  int map_f [N] = '{4,10,12,5,11,6,3,16,21,25,13,19,14,22,24,7,23,20,18,15,0,8,1,17,2,9};
  int inv_f [N];

  int total = 0;
  int bad   = 0;

  int q_f0[$], q_b0[$], q_f1[$], q_b1[$];

  // Reference model state
  int m_pos = 0, m_ring = 0;
  bit m_np0 = 0, m_np1 = 0, m_err = 0;

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int model_sub(int c, int p, int r, bit bwd);
    int idx, m;
    if (c >= N) return c;
    idx = ((c + p - r) % N + N) % N;
    m   = bwd ? inv_f[idx] : map_f[idx];
    return ((m - p + r) % N + N) % N;
  endfunction

  // Monitor: pop an expectation whenever a rotor presents a valid output.
  always @(negedge clk) begin
    if (bus0.out_valid_fwd) begin
      if (q_f0.size() == 0) chk("fwd0_unexpected", 1, 0);
      else chk("fwd0", int'(bus0.char_out_fwd), q_f0.pop_front());
    end
    if (bus0.out_valid_bwd) begin
      if (q_b0.size() == 0) chk("bwd0_unexpected", 1, 0);
      else chk("bwd0", int'(bus0.char_out_bwd), q_b0.pop_front());
    end
    if (bus1.out_valid_fwd) begin
      if (q_f1.size() == 0) chk("fwd1_unexpected", 1, 0);
      else chk("fwd1", int'(bus1.char_out_fwd), q_f1.pop_front());
    end
    if (bus1.out_valid_bwd) begin
      if (q_b1.size() == 0) chk("bwd1_unexpected", 1, 0);
      else chk("bwd1", int'(bus1.char_out_bwd), q_b1.pop_front());
    end
`ifndef ROTOR_PIPE_EN
    if (!bus0.out_valid_fwd) chk("fwd0_idle_zero", int'(bus0.char_out_fwd), 0);
    if (!bus0.out_valid_bwd) chk("bwd0_idle_zero", int'(bus0.char_out_bwd), 0);
`endif
  end

  // One clock cycle: check state left by the previous edge, then drive and predict.
  task automatic cyc(input bit r, input bit ld, input int ip, input int ir, input bit st,
                     input bit vf, input int cf, input bit vb, input int cb);
    int ef, eb;
    @(posedge clk); #1;
    chk("pos0",   int'(bus0.current_pos),  m_pos);
    chk("ring0",  int'(bus0.ring_setting), m_ring);
    chk("np0",    int'(bus0.notch_pulse),  int'(m_np0));
    chk("err0",   int'(bus0.config_err),   int'(m_err));
    chk("pos1",   int'(bus1.current_pos),  m_pos);
    chk("np1",    int'(bus1.notch_pulse),  int'(m_np1));
    chk("err1",   int'(bus1.config_err),   int'(m_err));
    chk("notch0", int'(bus0.at_notch),     int'(m_pos == 16));
    chk("notch1", int'(bus1.at_notch),     int'(m_pos == 25 || m_pos == 12));

    rst = r;
    bus0.load_config = ld;  bus1.load_config = ld;
    bus0.init_pos = W'(ip); bus1.init_pos = W'(ip);
    bus0.init_ring = W'(ir); bus1.init_ring = W'(ir);
    bus0.step_enable = st;  bus1.step_enable = st;
    bus0.in_valid_fwd = vf; bus1.in_valid_fwd = vf;
    bus0.char_in_fwd = W'(cf); bus1.char_in_fwd = W'(cf);
    bus0.in_valid_bwd = vb; bus1.in_valid_bwd = vb;
    bus0.char_in_bwd = W'(cb); bus1.char_in_bwd = W'(cb);

    ef = model_sub(cf, m_pos, m_ring, 1'b0);
    eb = model_sub(cb, m_pos, m_ring, 1'b1);
    if (vf && !(PIPE && r)) begin q_f0.push_back(ef); q_f1.push_back(ef); end
    if (vb && !(PIPE && r)) begin q_b0.push_back(eb); q_b1.push_back(eb); end

    if (r) begin
      m_pos = 0; m_ring = 0; m_np0 = 0; m_np1 = 0; m_err = 0;
    end else if (ld) begin
      m_np0 = 0; m_np1 = 0;
      if (ip >= N || ir >= N) m_err = 1;
      else begin m_err = 0; m_pos = ip; m_ring = ir; end
    end else if (st) begin
      m_np0 = (m_pos == 16);
      m_np1 = (m_pos == 25 || m_pos == 12);
      m_pos = (m_pos + 1) % N;
      m_err = 0;
    end else begin
      m_np0 = 0; m_np1 = 0; m_err = 0;
    end
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load(input int p, input int r);
    cyc(0, 1, p, r, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit r, ld, st, vf, vb;
    int ip, ir, cf, cb;
    for (int i = 0; i < N; i++) inv_f[map_f[i]] = i;

    bus0.load_config = 0; bus0.init_pos = '0; bus0.init_ring = '0; bus0.step_enable = 0;
    bus0.in_valid_fwd = 0; bus0.char_in_fwd = '0; bus0.in_valid_bwd = 0; bus0.char_in_bwd = '0;
    bus1.load_config = 0; bus1.init_pos = '0; bus1.init_ring = '0; bus1.step_enable = 0;
    bus1.in_valid_fwd = 0; bus1.char_in_fwd = '0; bus1.in_valid_bwd = 0; bus1.char_in_bwd = '0;

    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Test 1: pos 0 ring 0, fwd 0->4, bwd 4->0
    load(0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 1, 4);
    // Test 2: ring 1, fwd 0 -> 10
    load(0, 1);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Test 3: notch step 16->17 and non-notch step 17->18
    load(16, 0);
    cyc(0, 0, 0, 0, 1, 1, 3, 1, 7);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle();
    // Test 4: wrap from N-1
    load(25, 3);
    cyc(0, 0, 0, 0, 1, 1, 25, 1, 0);
    idle();
    // Test 5: load beats step, then rejected loads
    cyc(0, 1, 7, 2, 1, 0, 0, 0, 0);
    idle();
    load(30, 2);
    idle();
    load(5, 27);
    idle();
    // Test 6: dual-notch rotor stepping from 12 and from 25
    load(12, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    load(25, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle();
    // Out-of-alphabet symbols pass through unchanged
    cyc(0, 0, 0, 0, 0, 1, 28, 1, 31);
    // Reset mid-operation with traffic present
    load(9, 4);
    cyc(0, 0, 0, 0, 1, 1, 11, 1, 2);
    cyc(1, 0, 0, 0, 0, 1, 5, 1, 6);
    idle();

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      r  = ($urandom_range(0, 59) == 0);
      ld = ($urandom_range(0, 7) == 0);
      ip = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 31) : $urandom_range(0, N-1);
      ir = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 31) : $urandom_range(0, N-1);
      st = $urandom_range(0, 1);
      vf = $urandom_range(0, 1);
      vb = $urandom_range(0, 1);
      cf = $urandom_range(0, 31);
      cb = $urandom_range(0, 31);
      cyc(r, ld, ip, ir, st, vf, cf, vb, cb);
    end

    idle();
    idle();
    idle();
    chk("q_f0_drained", q_f0.size(), 0);
    chk("q_b0_drained", q_b0.size(), 0);
    chk("q_f1_drained", q_f1.size(), 0);
    chk("q_b1_drained", q_b1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
